// File: rtl/id_operand_unit_if.sv
// Bundle between the ID control unit, the EXE/MEM/WB stages and the decode-stage operand unit.
// The operand unit connects through the slave modport; the driving pipeline uses master.
interface id_operand_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            id_valid;
    logic            id_ready;
    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic [AW-1:0]   rd_addr;
    logic            id_wen;
    logic            id_is_load;
    logic            flush;
    logic [XLEN-1:0] exe_result;
    logic [XLEN-1:0] mem_result;
    logic            wb_wen;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic [1:0]      fwda;
    logic [1:0]      fwdb;
    logic [15:0]     stall_cnt;

    modport master (
        output id_valid, rs_addr, rt_addr, rd_addr, id_wen, id_is_load, flush,
        output exe_result, mem_result, wb_wen, wb_addr, wb_data,
        input  id_ready, da, db, fwda, fwdb, stall_cnt
    );

    modport slave (
        input  id_valid, rs_addr, rt_addr, rd_addr, id_wen, id_is_load, flush,
        input  exe_result, mem_result, wb_wen, wb_addr, wb_data,
        output id_ready, da, db, fwda, fwdb, stall_cnt
    );
endinterface

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: register file, EXE/MEM destination tracking, forwarding, load-use stall.
// Define ID_PERF_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt reads 0.
module id_operand_unit #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic              clk,
    input logic              reset,
    id_operand_unit_if.slave bus
);
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EXE = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic          is_load;
    } slot_t;

    logic [XLEN-1:0] regs_r [NREG];
    slot_t           exe_slot_r;
    slot_t           mem_slot_r;
    slot_t           exe_next_s;
    logic            hazard_s;
    logic            issue_s;
    logic [1:0]      sel_a_s;
    logic [1:0]      sel_b_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;

    // A load in EXE cannot supply its value yet, so it is skipped here and handled as a stall.
    function automatic logic [1:0] fwd_select(
        input logic [AW-1:0] src,
        input slot_t         exe,
        input slot_t         mem,
        input logic          wen,
        input logic [AW-1:0] waddr
    );
        logic [1:0] sel;
        if (src == ZERO_ADDR) begin
            sel = SEL_RF;
        end else if (exe.valid && (exe.addr == src) && !exe.is_load) begin
            sel = SEL_EXE;
        end else if (mem.valid && (mem.addr == src)) begin
            sel = SEL_MEM;
        end else if (wen && (waddr == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] operand_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] exe_val,
        input logic [XLEN-1:0] mem_val,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] val;
        case (sel)
            SEL_EXE: val = exe_val;
            SEL_MEM: val = mem_val;
            SEL_WB:  val = wb_val;
            default: val = rf_val;
        endcase
        return val;
    endfunction

    function automatic logic load_use(input logic [AW-1:0] src, input slot_t exe);
        return (src != ZERO_ADDR) && exe.valid && exe.is_load && (exe.addr == src);
    endfunction

    // Load-use hazard detection and the slot entry captured into EXE at the next edge
    always_comb begin
        hazard_s   = 1'b0;
        issue_s    = 1'b0;
        exe_next_s = '0;
        if (bus.id_valid && (load_use(bus.rs_addr, exe_slot_r) || load_use(bus.rt_addr, exe_slot_r))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        issue_s = bus.id_valid && !hazard_s && !bus.flush;
        if (issue_s) begin
            exe_next_s.valid   = bus.id_wen && (bus.rd_addr != ZERO_ADDR);
            exe_next_s.addr    = bus.rd_addr;
            exe_next_s.is_load = bus.id_is_load;
        end else begin
            exe_next_s = '0;
        end
    end

    // Forwarding select and operand value per source
    always_comb begin
        sel_a_s = fwd_select(bus.rs_addr, exe_slot_r, mem_slot_r, bus.wb_wen, bus.wb_addr);
        sel_b_s = fwd_select(bus.rt_addr, exe_slot_r, mem_slot_r, bus.wb_wen, bus.wb_addr);
        op_a_s  = operand_mux(sel_a_s, regs_r[bus.rs_addr], bus.exe_result, bus.mem_result, bus.wb_data);
        op_b_s  = operand_mux(sel_b_s, regs_r[bus.rt_addr], bus.exe_result, bus.mem_result, bus.wb_data);
    end

    // Outputs held quiet while reset is asserted, so a live WB bus cannot leak through the bypass
    always_comb begin
        bus.id_ready = 1'b1;
        bus.fwda     = SEL_RF;
        bus.fwdb     = SEL_RF;
        bus.da       = {XLEN{1'b0}};
        bus.db       = {XLEN{1'b0}};
        if (reset) begin
            bus.id_ready = 1'b1;
            bus.fwda     = SEL_RF;
            bus.fwdb     = SEL_RF;
            bus.da       = {XLEN{1'b0}};
            bus.db       = {XLEN{1'b0}};
        end else begin
            bus.id_ready = !hazard_s;
            bus.fwda     = sel_a_s;
            bus.fwdb     = sel_b_s;
            bus.da       = op_a_s;
            bus.db       = op_b_s;
        end
    end

    // Register file; register 0 is never written so it reads as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (bus.wb_wen && (bus.wb_addr != ZERO_ADDR)) begin
            regs_r[bus.wb_addr] <= bus.wb_data;
        end
    end

    // In-flight destination tracking: MEM always follows EXE, EXE takes the issue or a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_slot_r <= '0;
            mem_slot_r <= '0;
        end else begin
            mem_slot_r <= exe_slot_r;
            exe_slot_r <= exe_next_s;
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles in which ID was held by a load-use stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (bus.id_valid && hazard_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`else
    assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_id_operand_unit.sv
// Self-checking bench for id_operand_unit: directed scenarios followed by randomized traffic
// compared against an issue-history reference model.
module tb_id_operand_unit;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    id_operand_unit_if #(.XLEN(XLEN), .AW(AW)) bus ();

    id_operand_unit #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what was issued at each cycle, plus architectural register contents.
    int          cyc = 2;
    bit          lg_v  [MAXC];
    logic [4:0]  lg_rd [MAXC];
    bit          lg_ld [MAXC];
    logic [31:0] mregs [NREG];
    int          mcnt = 0;

    logic        obs_rdy;
    logic [1:0]  obs_fwda, obs_fwdb;
    logic [31:0] obs_da, obs_db;
    logic [15:0] obs_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < MAXC; k++) lg_v[k] = 1'b0;
        for (int k = 0; k < NREG; k++) mregs[k] = 32'd0;
        mcnt = 0;
    endtask

    // An instruction issued at cycle c sits in EXE during c+1 and in MEM during c+2.
    task automatic operand_exp(input logic [4:0] src, output logic [1:0] sel, output logic [31:0] val);
        int e;
        int m;
        e = cyc - 1;
        m = cyc - 2;
        if (src == 5'd0) begin
            sel = 2'd0; val = 32'd0;
        end else if (lg_v[e] && lg_rd[e] == src && !lg_ld[e]) begin
            sel = 2'd1; val = bus.exe_result;
        end else if (lg_v[m] && lg_rd[m] == src) begin
            sel = 2'd2; val = bus.mem_result;
        end else if (bus.wb_wen && bus.wb_addr == src) begin
            sel = 2'd3; val = bus.wb_data;
        end else begin
            sel = 2'd0; val = mregs[src];
        end
    endtask

    task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input bit wen, input bit ld, input bit fl,
                         input bit wbw, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic [31:0] exr, input logic [31:0] mmr);
        bus.id_valid   = v;
        bus.rs_addr    = rs;
        bus.rt_addr    = rt;
        bus.rd_addr    = rd;
        bus.id_wen     = wen;
        bus.id_is_load = ld;
        bus.flush      = fl;
        bus.wb_wen     = wbw;
        bus.wb_addr    = wba;
        bus.wb_data    = wbd;
        bus.exe_result = exr;
        bus.mem_result = mmr;
    endtask

    // Called at a falling edge with inputs driven: checks outputs, then advances model over one rising edge.
    task automatic cycle();
        logic [1:0]  esa, esb;
        logic [31:0] eda, edb;
        bit          hz, erdy;
        int          e;
        e = cyc - 1;
        hz = bus.id_valid && lg_v[e] && lg_ld[e] &&
             ((bus.rs_addr != 5'd0 && lg_rd[e] == bus.rs_addr) ||
              (bus.rt_addr != 5'd0 && lg_rd[e] == bus.rt_addr));
        erdy = !hz;
        operand_exp(bus.rs_addr, esa, eda);
        operand_exp(bus.rt_addr, esb, edb);
        #1;
        obs_rdy  = bus.id_ready;
        obs_fwda = bus.fwda;
        obs_fwdb = bus.fwdb;
        obs_da   = bus.da;
        obs_db   = bus.db;
        obs_cnt  = bus.stall_cnt;
        check_eq("id_ready", {31'd0, obs_rdy}, {31'd0, erdy});
        check_eq("fwda", {30'd0, obs_fwda}, {30'd0, esa});
        check_eq("fwdb", {30'd0, obs_fwdb}, {30'd0, esb});
        check_eq("da", obs_da, eda);
        check_eq("db", obs_db, edb);
        check_eq("stall_cnt", {16'd0, obs_cnt}, mcnt);
        @(posedge clk);
        lg_v[cyc]  = bus.id_valid && erdy && !bus.flush && bus.id_wen && (bus.rd_addr != 5'd0);
        lg_rd[cyc] = bus.rd_addr;
        lg_ld[cyc] = bus.id_is_load;
        if (bus.wb_wen && bus.wb_addr != 5'd0) mregs[bus.wb_addr] = bus.wb_data;
`ifdef ID_PERF_CNT_EN
        if (bus.id_valid && !erdy && mcnt < 65535) mcnt++;
`endif
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks the held-reset outputs, and releases at the next falling edge.
    task automatic reset_mid();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_ready", {31'd0, bus.id_ready}, 32'd1);
        check_eq("rst_fwda", {30'd0, bus.fwda}, 32'd0);
        check_eq("rst_fwdb", {30'd0, bus.fwdb}, 32'd0);
        check_eq("rst_da", bus.da, 32'd0);
        check_eq("rst_db", bus.db, 32'd0);
        check_eq("rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        model_clear();
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hCAFE_0001, 32'd1, 32'd2);
        #2;
        check_eq("por_ready", {31'd0, bus.id_ready}, 32'd1);
        check_eq("por_fwda", {30'd0, bus.fwda}, 32'd0);
        check_eq("por_da", bus.da, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset state: rs=5, rt=0 with nothing written
        drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        check_eq("t1_ready", {31'd0, obs_rdy}, 32'd1);
        check_eq("t1_da", obs_da, 32'd0);
        check_eq("t1_db", obs_db, 32'd0);
        check_eq("t1_fwda", {30'd0, obs_fwda}, 32'd0);

        // WB write-through then regfile read of r3
        drive(1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 32'd0, 32'd0);
        cycle();
        check_eq("t2_fwda_wb", {30'd0, obs_fwda}, 32'd3);
        check_eq("t2_da_wb", obs_da, 32'h1234);
        drive(1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        check_eq("t2_fwda_rf", {30'd0, obs_fwda}, 32'd0);
        check_eq("t2_da_rf", obs_da, 32'h1234);

        // ALU op to r4, consumed from EXE then MEM
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_00AA, 32'd0);
        cycle();
        check_eq("t3_fwda_exe", {30'd0, obs_fwda}, 32'd1);
        check_eq("t3_da_exe", obs_da, 32'h0000_00AA);
        drive(1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0000_00AA);
        cycle();
        check_eq("t3_fwda_mem", {30'd0, obs_fwda}, 32'd2);
        check_eq("t3_da_mem", obs_da, 32'h0000_00AA);

        // Load to r7 followed by a dependent read on rt: one stall cycle
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h0000_0055);
        cycle();
        check_eq("t4_stall", {31'd0, obs_rdy}, 32'd0);
        cycle();
        check_eq("t4_resume", {31'd0, obs_rdy}, 32'd1);
        check_eq("t4_fwdb", {30'd0, obs_fwdb}, 32'd2);
        check_eq("t4_db", obs_db, 32'h0000_0055);
`ifdef ID_PERF_CNT_EN
        check_eq("t4_cnt", {16'd0, obs_cnt}, 32'd1);
`else
        check_eq("t4_cnt", {16'd0, obs_cnt}, 32'd0);
`endif

        // Flushed load never occupies EXE
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h77, 32'h66);
        cycle();
        check_eq("t5_ready", {31'd0, obs_rdy}, 32'd1);
        check_eq("t5_fwda", {30'd0, obs_fwda}, 32'd0);
        check_eq("t5_da", obs_da, 32'd0);

        // Reset while a load sits in EXE, with a live WB to the same register
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'd5, 32'd6);
        reset_mid();
        drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd9, 32'd8);
        cycle();
        check_eq("t6_ready", {31'd0, obs_rdy}, 32'd1);
        check_eq("t6_da", obs_da, 32'd0);

        // Randomized traffic over a small register window to provoke collisions
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 400; i++) begin
                drive($urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom);
                cycle();
            end
            if (pass == 0) begin
                drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, $urandom, $urandom, $urandom);
                reset_mid();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
- Parametrised decode-stage operand unit for the 5-stage pipeline.
- Owns the register file and tracks in-flight destinations in the EXE and MEM slots.
- Generates forwarding selects and drives forwarded operands da/db.
- Detects load-use hazards and stalls ID through a ready handshake.
- Sits between the ID control unit and the EXE stage; the WB stage writes back into it.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers; register 0 is hardwired to zero
AW, 5, register address width; must equal clog2(NREG)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decoded instruction present in ID
id_ready  out  1  ID may advance; 0 = load-use stall
rs_addr  in  AW  source A register
rt_addr  in  AW  source B register
rd_addr  in  AW  destination register of ID instruction
id_wen  in  1  ID instruction writes rd_addr
id_is_load  in  1  ID instruction is a load
flush  in  1  kill the instruction entering EXE (branch/jump redirect)
exe_result  in  XLEN  ALU result of the instruction currently in EXE
mem_result  in  XLEN  result of the instruction in MEM (ALU value or load data)
wb_wen  in  1  writeback enable
wb_addr  in  AW  writeback register
wb_data  in  XLEN  writeback data
da  out  XLEN  forwarded operand A
db  out  XLEN  forwarded operand B
fwda  out  2  source select for A: 0 regfile, 1 EXE, 2 MEM, 3 WB bypass
fwdb  out  2  source select for B, same encoding as fwda
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Reset (asynchronous, active-high):
  - All NREG registers clear to 0.
  - EXE and MEM slots become invalid.
  - stall_cnt clears to 0.
  - While reset is held, id_ready=1, fwda=fwdb=0, da=db=0.
- Register file:
  - Written on the rising edge when wb_wen=1 and wb_addr!=0.
  - Writes to register 0 are ignored.
  - Reads are combinational.
- Slot state: each slot holds {valid, addr, is_load}.
  - Every rising edge: the MEM slot takes the EXE slot.
  - The EXE slot takes {id_wen && rd_addr!=0, rd_addr, id_is_load} when id_valid && id_ready && !flush; otherwise it takes a bubble (valid=0).
  - flush overrides the EXE-slot load only. The MEM slot still advances normally.
- Forwarding, per source (combinational, priority order):
  - Address 0 -> select 0, operand 0.
  - EXE slot valid, addr match, not a load -> select 1, exe_result.
  - MEM slot valid, addr match -> select 2, mem_result.
  - wb_wen && wb_addr match -> select 3, wb_data (write-through).
  - Otherwise -> select 0, regfile value.
- Hazard: id_ready = !(id_valid && EXE slot valid && EXE slot is_load && EXE addr matches nonzero rs_addr or rt_addr).
  - The stall lasts exactly 1 cycle. After it the load is in MEM and is forwarded from mem_result.
- Latency: operands are combinational from addresses in the same cycle. Slot state updates one cycle after issue.
- Simultaneous events:
  - flush during a stall -> a bubble is still inserted, with no double count.
  - WB to the same register in the same cycle as a read -> wb_data is returned, not the stale regfile value.
- Reset asserted mid-operation:
  - In-flight slots are discarded immediately; no writeback occurs for them.
  - After release, the first id_valid issues without a stall.

Optional Feature:
- Macro: ID_PERF_CNT_EN.
- Defined: stall_cnt increments on every rising edge where id_valid=1 and id_ready=0. It saturates at 16'hFFFF.
- Undefined: stall_cnt is tied to 0 and no counter flops are synthesised. All other behaviour is identical.

Test Plan:
- Reset, then read rs=5, rt=0 with no writes -> da=0, db=0, fwda=fwdb=0, id_ready=1.
- WB writes r3=32'h1234 while ID reads rs=3 in the same cycle -> fwda=3, da=32'h1234. The next cycle with no WB -> fwda=0, da=32'h1234.
- Issue an ALU op with rd=4 (non-load), then next cycle read rs=4 with exe_result=32'hAA -> fwda=1, da=32'hAA. The cycle after, with mem_result=32'hAA -> fwda=2.
- Issue a load with rd=7, then next cycle read rt=7 -> id_ready=0 for one cycle and stall_cnt=1 (with ID_PERF_CNT_EN). Then id_ready=1, fwdb=2, db=mem_result.
- Issue a load with rd=7 with flush asserted, then read rs=7 -> no stall (id_ready=1). The EXE slot is empty, so forwarding falls to WB or regfile.
- Assert reset while a load is in the EXE slot -> slots clear asynchronously. After release, read rs=7 -> id_ready=1, da=0.
